render_shape_driver: RTL and testbench

- Producer side of the shape renderer's stepping interface.
- Accepts a shape pose (screen position plus sin/cos of its rotation) over a valid/ready handshake.
- Computes the frame-start origin offsets ix/iy with a sequential multiplier during the frame.
- Commits the new pose atomically at the next frame boundary and emits the registered newframe/newline strobes that the renderer steps on.

---
 rtl/render_shape_driver_pkg.sv | 57 +++++
 rtl/render_shape_driver_if.sv | 21 ++
 rtl/render_shape_driver_mul_seq.sv | 49 ++++
 rtl/render_shape_driver.sv | 154 +++++++++++++++
 tb/tb_render_shape_driver.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/render_shape_driver_pkg.sv
// Shared types, widths and constants for render_shape_driver.
// Widths fall back to local defaults when the build does not predefine INT_BITS/FLOAT_BITS/FLOAT_DCM_BITS.
`ifndef INT_BITS
`define INT_BITS 10
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 24
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 12
`endif

package render_shape_driver_pkg;
    localparam int INT_W = `INT_BITS;
    localparam int FLT_W = `FLOAT_BITS;
    localparam int DCM_W = `FLOAT_DCM_BITS;

    typedef logic [INT_W-1:0]        pos_t;
    typedef logic signed [FLT_W-1:0] trig_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_PEND
    } state_t;

    typedef struct packed {
        pos_t  px;
        pos_t  py;
        trig_t sin;
        trig_t cos;
    } pose_t;

    localparam trig_t Q_ONE = trig_t'(longint'(1) << DCM_W);
    // sqrt(1/2) as a 32-bit binary fraction, rounded to nearest in the Q format
    localparam longint SQRT_HALF_U32 = 64'sd3037000500;
    localparam trig_t  Q_S45 = trig_t'(((SQRT_HALF_U32 << DCM_W) + 64'sd2147483648) >>> 32);

    function automatic trig_t lut_sin(input logic [2:0] k);
        trig_t v;
        case (k)
            3'd0:    v = '0;
            3'd1:    v = Q_S45;
            3'd2:    v = Q_ONE;
            3'd3:    v = Q_S45;
            3'd4:    v = '0;
            3'd5:    v = -Q_S45;
            3'd6:    v = -Q_ONE;
            default: v = -Q_S45;
        endcase
        return v;
    endfunction

    function automatic trig_t lut_cos(input logic [2:0] k);
        return lut_sin(k + 3'd2);
    endfunction
endpackage

// File: rtl/render_shape_driver_if.sv
// Pose configuration handshake between a pose producer (master) and render_shape_driver (slave).
// cfg_angle exists only when RENDER_SHAPE_DRIVER_ANGLE_LUT_EN is defined.
interface render_shape_driver_if;
    import render_shape_driver_pkg::*;

    logic  cfg_valid;
    logic  cfg_ready;
    pos_t  cfg_px;
    pos_t  cfg_py;
    trig_t cfg_sin;
    trig_t cfg_cos;
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
    logic [2:0] cfg_angle;

    modport master (output cfg_valid, cfg_px, cfg_py, cfg_sin, cfg_cos, cfg_angle, input cfg_ready);
    modport slave  (input cfg_valid, cfg_px, cfg_py, cfg_sin, cfg_cos, cfg_angle, output cfg_ready);
`else
    modport master (output cfg_valid, cfg_px, cfg_py, cfg_sin, cfg_cos, input cfg_ready);
    modport slave  (input cfg_valid, cfg_px, cfg_py, cfg_sin, cfg_cos, output cfg_ready);
`endif
endinterface

// File: rtl/render_shape_driver_mul_seq.sv
// Iterative shift-add multiplier: signed multiplicand times unsigned multiplier, one bit per cycle.
// done_o marks the last iteration cycle; result_o then holds the full product truncated to trig width.
module render_shape_driver_mul_seq
    import render_shape_driver_pkg::*;
#(
    parameter int MUL_W = INT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  trig_t            mcand_i,
    input  logic [MUL_W-1:0] mplier_i,
    output logic             done_o,
    output trig_t            result_o
);
    localparam int CNT_W = $clog2(MUL_W + 1);

    trig_t            a_q;
    trig_t            acc_q;
    logic [MUL_W-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    assign result_o = acc_q + (b_q[0] ? a_q : '0);
    assign done_o   = run_q && (cnt_q == CNT_W'(1));

    // start may coincide with the last iteration of the previous product; result_o is consumed that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            a_q   <= mcand_i;
            acc_q <= '0;
            b_q   <= mplier_i;
            cnt_q <= CNT_W'(MUL_W);
            run_q <= 1'b1;
        end else if (run_q) begin
            a_q   <= a_q << 1;
            acc_q <= result_o;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - 1'b1;
            run_q <= (cnt_q != CNT_W'(1));
        end
    end
endmodule

// File: rtl/render_shape_driver.sv
// Pose producer for the shape renderer: computes frame-start offsets and commits the pose on frame_begin.
// Optional 45-degree angle LUT input selected by RENDER_SHAPE_DRIVER_ANGLE_LUT_EN.
//   state | meaning
//   IDLE  | ready for a new pose
//   CALC  | four shared-multiplier products into shadow ix/iy
//   PEND  | shadow pose complete, waiting for frame_begin to commit
module render_shape_driver
    import render_shape_driver_pkg::*;
#(
    parameter int MUL_W = INT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_begin,
    input  logic                  line_begin,
    render_shape_driver_if.slave  cfg,
    output logic                  newframe,
    output logic                  newline,
    output trig_t                 sin,
    output trig_t                 cos,
    output trig_t                 ix,
    output trig_t                 iy,
    output logic                  busy
);
    state_t     state_q, state_d;
    pose_t      pose_q, pose_d, pose_in, op_src;
    trig_t      ix_sh_q, ix_sh_d, iy_sh_q, iy_sh_d;
    trig_t      sin_q, sin_d, cos_q, cos_d, ix_q, ix_d, iy_q, iy_d;
    logic [1:0] prod_q, prod_d, op_sel;
    logic       newframe_q, newline_q;
    logic       mul_start, mul_done;
    trig_t      mul_mcand, mul_res;
    pos_t       mul_pos;

    always_comb begin
        pose_in.px  = cfg.cfg_px;
        pose_in.py  = cfg.cfg_py;
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
        pose_in.sin = lut_sin(cfg.cfg_angle);
        pose_in.cos = lut_cos(cfg.cfg_angle);
`else
        pose_in.sin = cfg.cfg_sin;
        pose_in.cos = cfg.cfg_cos;
`endif
    end

    // Product order: px*cos, py*sin, px*sin, py*cos; the first one starts straight from the accept cycle
    always_comb begin
        op_sel = (state_q == ST_IDLE) ? 2'd0 : prod_q + 2'd1;
        op_src = (state_q == ST_IDLE) ? pose_in : pose_q;
        case (op_sel)
            2'd0:    begin mul_mcand = op_src.cos; mul_pos = op_src.px; end
            2'd1:    begin mul_mcand = op_src.sin; mul_pos = op_src.py; end
            2'd2:    begin mul_mcand = op_src.sin; mul_pos = op_src.px; end
            default: begin mul_mcand = op_src.cos; mul_pos = op_src.py; end
        endcase
    end

    render_shape_driver_mul_seq #(.MUL_W(MUL_W)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .mcand_i  (mul_mcand),
        .mplier_i (MUL_W'(mul_pos)),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    always_comb begin
        state_d   = state_q;
        pose_d    = pose_q;
        ix_sh_d   = ix_sh_q;
        iy_sh_d   = iy_sh_q;
        prod_d    = prod_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    pose_d    = pose_in;
                    prod_d    = 2'd0;
                    mul_start = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mul_done) begin
                    case (prod_q)
                        2'd0:    ix_sh_d = -mul_res;
                        2'd1:    ix_sh_d = ix_sh_q + mul_res;
                        2'd2:    iy_sh_d = -mul_res;
                        default: iy_sh_d = iy_sh_q - mul_res;
                    endcase
                    if (prod_q == 2'd3) begin
                        state_d = ST_PEND;
                    end else begin
                        prod_d    = prod_q + 2'd1;
                        mul_start = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (frame_begin) begin
                    sin_d   = pose_q.sin;
                    cos_d   = pose_q.cos;
                    ix_d    = ix_sh_q;
                    iy_d    = iy_sh_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pose_q     <= '0;
            ix_sh_q    <= '0;
            iy_sh_q    <= '0;
            prod_q     <= '0;
            sin_q      <= '0;
            cos_q      <= Q_ONE;
            ix_q       <= '0;
            iy_q       <= '0;
            newframe_q <= 1'b0;
            newline_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pose_q     <= pose_d;
            ix_sh_q    <= ix_sh_d;
            iy_sh_q    <= iy_sh_d;
            prod_q     <= prod_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            ix_q       <= ix_d;
            iy_q       <= iy_d;
            newframe_q <= frame_begin;
            newline_q  <= line_begin & ~frame_begin;
        end
    end

    assign cfg.cfg_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign newframe      = newframe_q;
    assign newline       = newline_q;
    assign sin           = sin_q;
    assign cos           = cos_q;
    assign ix            = ix_q;
    assign iy            = iy_q;
endmodule

// File: tb/tb_render_shape_driver.sv
// Self-checking bench for render_shape_driver: cycle-level pose model plus directed literal checks.
module tb_render_shape_driver;
    import render_shape_driver_pkg::*;

    localparam int MW       = INT_W;
    localparam int CALC_CYC = 4 * MW;

    logic  clk, rst_n, frame_begin, line_begin, newframe, newline, busy;
    trig_t sin, cos, ix, iy;

    render_shape_driver_if cfg_if ();

    render_shape_driver #(.MUL_W(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_begin (frame_begin),
        .line_begin  (line_begin),
        .cfg         (cfg_if),
        .newframe    (newframe),
        .newline     (newline),
        .sin         (sin),
        .cos         (cos),
        .ix          (ix),
        .iy          (iy),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic trig_t q(input longint v);
        return trig_t'(v);
    endfunction

`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
    function automatic trig_t trig_of(input int k);
        real x;
        x = real'(Q_ONE) * $sin(real'(k) * 3.14159265358979 / 4.0);
        return trig_t'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
    endfunction
`endif

    // Model: pose pending from accept edge; commit allowed on frame_begin once CALC_CYC edges have elapsed
    trig_t m_sin = '0, m_cos = Q_ONE, m_ix = '0, m_iy = '0;
    trig_t p_sin, p_cos, p_ix, p_iy;
    logic  m_nf = 1'b0, m_nl = 1'b0, m_busy = 1'b0;
    int    edge_n = 0, accept_edge = 0;

    always @(posedge clk or negedge rst_n) begin
        longint px, py, s, c;
        if (!rst_n) begin
            m_sin = '0; m_cos = Q_ONE; m_ix = '0; m_iy = '0;
            m_nf = 1'b0; m_nl = 1'b0; m_busy = 1'b0; edge_n = 0;
        end else begin
            edge_n++;
            if (m_busy) begin
                if (frame_begin && edge_n >= accept_edge + CALC_CYC + 1) begin
                    m_sin = p_sin; m_cos = p_cos; m_ix = p_ix; m_iy = p_iy;
                    m_busy = 1'b0;
                end
            end else if (cfg_if.cfg_valid) begin
                px = longint'(cfg_if.cfg_px);
                py = longint'(cfg_if.cfg_py);
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
                s = longint'(trig_of(int'(cfg_if.cfg_angle)));
                c = longint'(trig_of(int'(cfg_if.cfg_angle) + 2));
`else
                s = longint'(cfg_if.cfg_sin);
                c = longint'(cfg_if.cfg_cos);
`endif
                p_sin = q(s); p_cos = q(c);
                p_ix  = q(-(px * c - py * s));
                p_iy  = q(-(px * s + py * c));
                m_busy = 1'b1;
                accept_edge = edge_n;
            end
            m_nf = frame_begin;
            m_nl = line_begin & ~frame_begin;
        end
    end

    always @(negedge clk) begin
        chk("sin",       sin,              m_sin);
        chk("cos",       cos,              m_cos);
        chk("ix",        ix,               m_ix);
        chk("iy",        iy,               m_iy);
        chk("newframe",  newframe,         m_nf);
        chk("newline",   newline,          m_nl);
        chk("cfg_ready", cfg_if.cfg_ready, !m_busy);
        chk("busy",      busy,             m_busy);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_frame();
        frame_begin = 1'b1;
        line_begin  = 1'b1;
        tick();
        frame_begin = 1'b0;
        line_begin  = 1'b0;
    endtask

    task automatic offer(input int px, input int py, input int s, input int c, input int ang, input logic fb);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_px    = pos_t'(px);
        cfg_if.cfg_py    = pos_t'(py);
        cfg_if.cfg_sin   = trig_t'(s);
        cfg_if.cfg_cos   = trig_t'(c);
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
        cfg_if.cfg_angle = 3'(ang);
`endif
        frame_begin = fb;
        line_begin  = fb;
        tick();
        cfg_if.cfg_valid = 1'b0;
        frame_begin = 1'b0;
        line_begin  = 1'b0;
        // inputs wander while not ready; they must not matter
        cfg_if.cfg_px  = pos_t'($urandom);
        cfg_if.cfg_py  = pos_t'($urandom);
        cfg_if.cfg_sin = trig_t'($urandom);
        cfg_if.cfg_cos = trig_t'($urandom);
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
        cfg_if.cfg_angle = 3'($urandom);
        cfg_if.cfg_valid = 1'b0;
`endif
        if (ang < 0) $display("bad angle argument");
    endtask

    initial begin
        longint lx, ly;
        rst_n = 1'b0; frame_begin = 1'b0; line_begin = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_px = '0; cfg_if.cfg_py = '0;
        cfg_if.cfg_sin = '0; cfg_if.cfg_cos = '0;
`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
        cfg_if.cfg_angle = '0;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // reset state and strobe latency
        @(negedge clk);
        chk("rst_sin", sin, q(0));
        chk("rst_cos", cos, q(4096 * (Q_ONE / 4096) + Q_ONE % 4096));
        chk("rst_ix", ix, q(0));
        chk("rst_iy", iy, q(0));
        chk("rst_ready", cfg_if.cfg_ready, 1);
        tick();
        pulse_frame();
        @(negedge clk);
        chk("nf_latency", newframe, 1);
        chk("nl_excl", newline, 0);
        tick();
        line_begin = 1'b1;
        tick();
        line_begin = 1'b0;
        @(negedge clk);
        chk("nl_latency", newline, 1);
        chk("nl_nf_low", newframe, 0);

        // identity rotation, committed on the earliest allowed frame_begin
        tick();
        offer(100, 50, 0, int'(Q_ONE), 0, 1'b0);
        repeat (CALC_CYC) tick();
        chk("pend_ready", cfg_if.cfg_ready, 0);
        chk("pend_ix_old", ix, q(0));
        pulse_frame();
        @(negedge clk);
        chk("commit_nf", newframe, 1);
        chk("commit_ix", ix, q(-100 * longint'(Q_ONE)));
        chk("commit_iy", iy, q(-50 * longint'(Q_ONE)));

        // 90 degrees; first frame_begin arrives one edge too early
        tick();
        offer(100, 50, int'(Q_ONE), 0, 0, 1'b0);
        repeat (CALC_CYC - 1) tick();
        pulse_frame();
        @(negedge clk);
        chk("early_ix", ix, q(-100 * longint'(Q_ONE)));
        chk("early_busy", busy, 1);
        tick();
        pulse_frame();
        @(negedge clk);
        chk("rot_ix", ix, q(50 * longint'(Q_ONE)));
        chk("rot_iy", iy, q(-100 * longint'(Q_ONE)));
        lx = longint'(ix) + 100 * longint'(cos) - 50 * longint'(sin);
        ly = longint'(iy) + 100 * longint'(sin) + 50 * longint'(cos);
        chk("render_lx", q(lx), q(0));
        chk("render_ly", q(ly), q(0));

        // frame_begin 3 cycles after accept: old pose holds, commit on the next frame
        tick();
        offer(7, 3, 1000, -2000, 0, 1'b0);
        repeat (2) tick();
        pulse_frame();
        @(negedge clk);
        chk("midcalc_ix", ix, q(50 * longint'(Q_ONE)));
        chk("midcalc_ready", cfg_if.cfg_ready, 0);
        repeat (CALC_CYC) tick();
        pulse_frame();
        @(negedge clk);
        chk("late_ix", ix, q(17000));
        chk("late_iy", iy, q(-1000));

        // accept in the same cycle as frame_begin, then a wrapping pose
        tick();
        offer(200, 10, 300, 4000, 0, 1'b1);
        @(negedge clk);
        chk("same_cyc_ix", ix, q(17000));
        chk("same_cyc_nf", newframe, 1);
        repeat (CALC_CYC + 2) tick();
        pulse_frame();
        @(negedge clk);
        chk("same_ix", ix, q(-797000));
        chk("same_iy", iy, q(-100000));
        tick();
        offer(1023, 1023, -8000000, 7999999, 0, 1'b0);
        repeat (CALC_CYC + 3) tick();
        pulse_frame();
        repeat (2) tick();

        // reset while pending discards the pose
        offer(33, 44, 500, 600, 0, 1'b0);
        repeat (CALC_CYC + 2) tick();
        chk("pend_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pend_cos", cos, Q_ONE);
        chk("rst_pend_ix", ix, q(0));
        chk("rst_pend_ready", cfg_if.cfg_ready, 1);
        tick();
        pulse_frame();
        @(negedge clk);
        chk("rst_pend_after_fb", ix, q(0));
        chk("rst_pend_sin_after_fb", sin, q(0));

`ifdef RENDER_SHAPE_DRIVER_ANGLE_LUT_EN
        tick();
        offer(10, 0, 12345, -777, 2, 1'b0);
        repeat (CALC_CYC + 1) tick();
        pulse_frame();
        @(negedge clk);
        chk("lut_sin", sin, Q_ONE);
        chk("lut_cos", cos, q(0));
        chk("lut_ix", ix, q(0));
        chk("lut_iy", iy, q(-10 * longint'(Q_ONE)));
        tick();
        offer(20, 30, 0, 0, 3, 1'b0);
        repeat (CALC_CYC + 1) tick();
        pulse_frame();
        @(negedge clk);
        chk("lut_s135", sin, q(2896));
        chk("lut_c135", cos, q(-2896));
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
